// File: rtl/timer_pkg.sv
// Shared encodings for the irrigation timer chain: FSM states and reload modes.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter_datapath.sv
// Count and reload registers for one timer stage: clamp on load,
// decrement or reload on command, zero decode straight from the count register.
module down_counter_datapath
    import timer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic             dec_en,
    input  logic             reload_en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] clamped_value;

    assign clamped_value = (load_value > MAX_V) ? MAX_V : load_value;

    // Controls are mutually exclusive from the FSM; the order only documents intent.
    always_comb begin
        count_next = count_reg;
        if (load_en) begin
            count_next = clamped_value;
        end else if (reload_en) begin
            count_next = reload_reg;
        end else if (dec_en) begin
            count_next = count_reg - 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_count_bit
            flipflop_d u_ff (
                .clock (clock),
                .reset (reset),
                .set   (1'b0),
                .d     (count_next[gi]),
                .q     (count_reg[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reload_reg <= MAX_V;
        end else if (load_en) begin
            reload_reg <= clamped_value;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/flipflop_d.sv
// Single D flip-flop with asynchronous reset and synchronous set.
module flipflop_d (
    input  logic clock,
    input  logic reset,
    input  logic set,
    input  logic d,
    output logic q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter stage with start/stop control, one-shot or periodic
// reload, and a registered borrow pulse that ticks the next stage.
module down_counter_timer
    import timer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             tick,
    output logic [WIDTH-1:0] q_bus,
    output logic             zero,
    output logic             borrow_out,
    output logic             running,
    output logic             done
);

    state_t state_reg;
    state_t state_next;
    logic   load_en;
    logic   dec_en;
    logic   reload_en;
    logic   expire;
    logic   borrow_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            borrow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            borrow_reg <= expire;
        end
    end

    // Priority load > stop > start > tick; any control input consumes the cycle's tick.
    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        dec_en     = 1'b0;
        reload_en  = 1'b0;
        expire     = 1'b0;
        if (load) begin
            load_en    = 1'b1;
            state_next = ST_IDLE;
        end else if (stop) begin
            if (state_reg == ST_RUNNING) begin
                state_next = ST_IDLE;
            end
        end else if (start) begin
            case (state_reg)
                ST_IDLE:    state_next = ST_RUNNING;
                ST_EXPIRED: begin
                    state_next = ST_RUNNING;
                    reload_en  = 1'b1;
                end
                default:    state_next = state_reg;
            endcase
        end else if (tick && state_reg == ST_RUNNING) begin
            if (zero) begin
                expire = 1'b1;
                if (periodic == MODE_PERIODIC) begin
                    reload_en = 1'b1;
                end else begin
                    state_next = ST_EXPIRED;
                end
            end else begin
                dec_en = 1'b1;
            end
        end
    end

    down_counter_datapath #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE)
    ) u_datapath (
        .clock      (clock),
        .reset      (reset),
        .load_en    (load_en),
        .dec_en     (dec_en),
        .reload_en  (reload_en),
        .load_value (load_value),
        .count      (q_bus),
        .zero       (zero)
    );

    assign borrow_out = borrow_reg;
    assign running    = (state_reg == ST_RUNNING);
    assign done       = (state_reg == ST_EXPIRED);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: vector table, directed corner
// sequences, a two-stage chain and randomized traffic against a reference model.
module tb_down_counter_timer;

    localparam int WIDTH = 4;
    localparam int MAXV  = 9;

    logic             clock = 1'b0;
    logic             reset;
    logic             load, start, stop, periodic, tick;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] q_bus;
    logic             zero, borrow_out, running, done;

    logic             b_load, b_start, b_stop, b_periodic;
    logic [WIDTH-1:0] b_load_value;
    logic [WIDTH-1:0] b_q_bus;
    logic             b_zero, b_borrow_out, b_running, b_done;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: phase 0 = idle, 1 = running, 2 = expired
    int m_count, m_reload, m_phase, m_borrow;

    always #5 clock = ~clock;

    down_counter_timer #(.WIDTH(WIDTH), .MAX_VALUE(MAXV)) dut_a (
        .clock(clock), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .periodic(periodic), .tick(tick),
        .q_bus(q_bus), .zero(zero), .borrow_out(borrow_out),
        .running(running), .done(done)
    );

    down_counter_timer #(.WIDTH(WIDTH), .MAX_VALUE(MAXV)) dut_b (
        .clock(clock), .reset(reset), .load(b_load), .load_value(b_load_value),
        .start(b_start), .stop(b_stop), .periodic(b_periodic), .tick(borrow_out),
        .q_bus(b_q_bus), .zero(b_zero), .borrow_out(b_borrow_out),
        .running(b_running), .done(b_done)
    );

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       sp;
        logic       per;
        logic       tk;
        int         q;
        logic       bo;
        logic       run;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_reload = MAXV; m_phase = 0; m_borrow = 0;
    endtask

    // Behavioural rules applied to one clock of inputs.
    task automatic model_step(input logic ld, input int lv, input logic st,
                              input logic sp, input logic per, input logic tk);
        m_borrow = 0;
        if (ld) begin
            m_count  = (lv > MAXV) ? MAXV : lv;
            m_reload = m_count;
            m_phase  = 0;
        end else if (sp) begin
            if (m_phase == 1) m_phase = 0;
        end else if (st) begin
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 2) begin
                m_phase = 1;
                m_count = m_reload;
            end
        end else if (tk && m_phase == 1) begin
            if (m_count > 0) m_count = m_count - 1;
            else begin
                m_borrow = 1;
                if (per) m_count = m_reload;
                else m_phase = 2;
            end
        end
    endtask

    task automatic drive(input logic ld, input int lv, input logic st,
                         input logic sp, input logic per, input logic tk);
        load = ld; load_value = WIDTH'(lv); start = st; stop = sp;
        periodic = per; tick = tk;
        model_step(ld, lv, st, sp, per, tk);
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},       int'(q_bus),      m_count);
        check({tag, ".zero"},    int'(zero),       int'(m_count == 0));
        check({tag, ".borrow"},  int'(borrow_out), m_borrow);
        check({tag, ".running"}, int'(running),    int'(m_phase == 1));
        check({tag, ".done"},    int'(done),       int'(m_phase == 2));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        load = 0; load_value = 0; start = 0; stop = 0; periodic = 0; tick = 0;
        b_load = 0; b_load_value = 0; b_start = 0; b_stop = 0; b_periodic = 0;
        do_reset();

        check("reset.q", int'(q_bus), 0);
        check("reset.zero", int'(zero), 1);
        check("reset.running", int'(running), 0);
        check("reset.done", int'(done), 0);
        check("reset.borrow", int'(borrow_out), 0);

        // one-shot from 5, then clamp / stop-with-tick / resume
        vecs = '{
            '{1,5,0,0,0,0, 5,0,0,0}, '{0,0,1,0,0,0, 5,0,1,0},
            '{0,0,0,0,0,1, 4,0,1,0}, '{0,0,0,0,0,1, 3,0,1,0},
            '{0,0,0,0,0,1, 2,0,1,0}, '{0,0,0,0,0,1, 1,0,1,0},
            '{0,0,0,0,0,1, 0,0,1,0}, '{0,0,0,0,0,1, 0,1,0,1},
            '{0,0,0,0,0,1, 0,0,0,1}, '{0,0,0,0,0,1, 0,0,0,1},
            '{1,15,0,0,0,0, 9,0,0,0}, '{0,0,1,0,0,0, 9,0,1,0},
            '{0,0,0,0,0,1, 8,0,1,0}, '{0,0,0,0,0,1, 7,0,1,0},
            '{0,0,0,0,0,1, 6,0,1,0}, '{0,0,0,0,0,1, 5,0,1,0},
            '{0,0,0,1,0,1, 5,0,0,0}, '{0,0,0,0,0,1, 5,0,0,0},
            '{0,0,1,0,0,1, 5,0,1,0}, '{0,0,0,0,0,1, 4,0,1,0},
            '{0,0,0,0,0,1, 3,0,1,0}, '{1,0,0,0,0,0, 0,0,0,0},
            '{0,0,1,0,0,0, 0,0,1,0}, '{0,0,0,0,0,1, 0,1,0,1}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ld, int'(vecs[i].lv), vecs[i].st, vecs[i].sp, vecs[i].per, vecs[i].tk);
            check($sformatf("vec%0d.q", i), int'(q_bus), vecs[i].q);
            check($sformatf("vec%0d.borrow", i), int'(borrow_out), int'(vecs[i].bo));
            check($sformatf("vec%0d.running", i), int'(running), int'(vecs[i].run));
            check($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].dn));
            $display("vec %0d: q=%0d borrow=%0d running=%0d done=%0d", i, q_bus, borrow_out, running, done);
        end

        // periodic modulus-4: borrow on ticks 4, 8, 12, one cycle wide
        drive(1, 3, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, 0, 0, 1, 1);
            check($sformatf("per.tick%0d.q", k), int'(q_bus), 3 - (k % 4));
            check($sformatf("per.tick%0d.borrow", k), int'(borrow_out), int'(k % 4 == 0));
            check($sformatf("per.tick%0d.running", k), int'(running), 1);
        end
        drive(0, 0, 0, 0, 1, 0);
        check("per.tail.borrow", int'(borrow_out), 0);

        // two-stage chain: A mod-10 periodic feeds B one-shot from 5
        do_reset();
        b_load = 1; b_load_value = 4'd5; b_periodic = 0;
        drive(1, 9, 0, 0, 1, 0);
        b_load = 0; b_start = 1;
        drive(0, 0, 1, 0, 1, 0);
        b_start = 0;
        for (int k = 1; k <= 60; k++) begin
            drive(0, 0, 0, 0, 1, 1);
            if (k % 10 == 1 || k % 10 == 0)
                check($sformatf("chain.tick%0d.b_q", k), int'(b_q_bus), 5 - (k - 1) / 10);
        end
        check("chain.b_done_early", int'(b_done), 0);
        drive(0, 0, 0, 0, 1, 0);
        check("chain.b_done", int'(b_done), 1);
        check("chain.b_borrow", int'(b_borrow_out), 1);
        check("chain.b_running", int'(b_running), 0);
        $display("chain: b_q=%0d b_done=%0d", b_q_bus, b_done);

        // asynchronous reset mid-count
        drive(1, 9, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 1);
        check("areset.pre_q", int'(q_bus), 6);
        #2 reset = 1'b1;
        #1;
        check("areset.q", int'(q_bus), 0);
        check("areset.running", int'(running), 0);
        check("areset.zero", int'(zero), 1);
        model_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            check_model($sformatf("areset.after%0d", k));
        end

        // randomized traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            logic ld, st, sp, per, tk;
            int   lv;
            ld  = ($urandom_range(0, 99) < 5);
            sp  = ($urandom_range(0, 99) < 5);
            st  = ($urandom_range(0, 99) < 12);
            per = $urandom_range(0, 1) == 1;
            tk  = ($urandom_range(0, 99) < 70);
            lv  = $urandom_range(0, 15);
            drive(ld, lv, st, sp, per, tk);
            check_model($sformatf("rand%0d", n));
            if (n % 50 == 0)
                $display("rand %0d: q=%0d model=%0d running=%0d done=%0d", n, q_bus, m_count, running, done);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Parametrised, loadable down-counter for the irrigation timer chain.
- Generalises the fixed 2-bit count-down stage to WIDTH bits with a programmable modulus.
- Adds start/stop/pause control, one-shot or periodic reload, and a registered borrow pulse for cascading stages (e.g. seconds -> minutes -> hours).
- Each stage advances only on its tick input, driven by the prescaler or by the previous stage's borrow_out.

Parameters:
- WIDTH, 4, count register width in bits.
- MAX_VALUE, 9, largest legal count and the reset reload value; must satisfy MAX_VALUE <= 2^WIDTH-1.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- load  input  1  load load_value into count and reload registers.
- load_value  input  WIDTH  value for load; values above MAX_VALUE are clamped to MAX_VALUE.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting; count is held.
- periodic  input  1  1 = reload on expiry and keep running; 0 = one-shot.
- tick  input  1  count-enable strobe; at most one decrement per clock.
- q_bus  output  WIDTH  current count.
- zero  output  1  high while q_bus == 0 (decoded from the count register).
- borrow_out  output  1  one-cycle pulse on every expiry; feeds the next stage's tick.
- running  output  1  high in state RUNNING.
- done  output  1  high in state EXPIRED (one-shot finished).

Behaviour:
- FSM states: IDLE, RUNNING, EXPIRED.
- Reset values: state = IDLE, count = 0, reload_reg = MAX_VALUE, borrow_out = 0, running = 0, done = 0, zero = 1.
- Per-cycle priority: reset > load > stop > start > tick.
- load (any state):
  - count <= clamp(load_value) and reload_reg <= clamp(load_value).
  - state <= IDLE, done cleared, tick ignored that cycle.
- stop:
  - RUNNING -> IDLE; count held; tick ignored that cycle.
  - No effect in IDLE or EXPIRED.
- start:
  - IDLE -> RUNNING with count unchanged (resume).
  - EXPIRED -> RUNNING with count <= reload_reg.
  - No effect in RUNNING.
  - A tick in the same cycle as start is not counted.
  - start and stop together: stop wins.
- tick in RUNNING, count > 0: count <= count - 1.
- tick in RUNNING, count == 0 (expiry):
  - borrow_out high for exactly the next cycle, coincident with the new count value.
  - periodic = 1: count <= reload_reg; stay RUNNING.
  - periodic = 0: count stays 0; state <= EXPIRED.
- Expiry timing: a count of N reaches expiry on tick N+1. Period is reload_reg+1 ticks, so a modulus-10 stage uses reload 9.
- Loading 0 then start: the first tick expires immediately.
- tick while IDLE or EXPIRED: ignored, no borrow.
- periodic is sampled only at expiry; changing it mid-count is legal.
- Count never goes below 0 and never exceeds MAX_VALUE.
- All outputs are registered or decoded directly from registers; no combinational path from inputs to outputs.
- Reset asserted mid-count: outputs reach reset values asynchronously. Counting resumes only after a later start.

Decomposition:
- Shared package timer_pkg holds:
  - FSM state encodings ST_IDLE = 2'd0, ST_RUNNING = 2'd1, ST_EXPIRED = 2'd2.
  - Mode constants MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1.
- Sub-module down_counter_datapath: count register, reload register, clamp, decrement/reload mux and zero decode. It is controlled by load_en, dec_en and reload_en from the FSM in the top module.
- The count register bits are instances of the existing flipflop_d, with reset tied to reset and set tied low.

Test Plan:
- Reset release with WIDTH=4, MAX_VALUE=9 -> q_bus=0, zero=1, running=0, done=0, borrow_out=0.
- load 5, periodic=0, start, then a tick every cycle -> q_bus 5,4,3,2,1,0. The 6th tick gives one borrow_out pulse, done=1, running=0, q_bus stays 0. Further ticks change nothing.
- load 3, periodic=1, start, 12 continuous ticks -> sequence 3,2,1,0,3,2,1,0,3,... with a borrow_out pulse on ticks 4, 8 and 12, each exactly one cycle wide.
- load 15 with MAX_VALUE=9 -> q_bus=9. start, 4 ticks -> q_bus=5. stop with a simultaneous tick -> q_bus stays 5. start -> resumes 4,3,... on subsequent ticks.
- Two stages chained (stage B tick = stage A borrow_out), A loaded 9 periodic, B loaded 5 one-shot -> B decrements once per 10 A-ticks. B done after 60 A-ticks.
- Assert reset asynchronously mid-count at q_bus=6 -> q_bus=0 and running=0 before the next clock edge. Ticks afterwards are ignored until load/start.
